// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time against a 64-bit doubleword memory.
// Sub-doubleword stores use read-modify-write; misaligned accesses trap only when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit #(
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      r_state, w_next;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_cnt;
    logic [63:0] w_align_addr, w_mask_lo, w_mask, w_merge, w_field, w_ext;
    logic [5:0]  w_shift;
    logic        w_rd_last;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    logic w_misalign;
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            2'b11:   w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end
`endif

    always_comb begin
        w_align_addr = req_addr;
        case (req_size)
            2'b01:   w_align_addr = {req_addr[63:1], 1'b0};
            2'b10:   w_align_addr = {req_addr[63:2], 2'b00};
            2'b11:   w_align_addr = {req_addr[63:3], 3'b000};
            default: w_align_addr = req_addr;
        endcase
    end

    // Lane arithmetic on the captured request: field at bits [8*offset +: 8*bytes].
    always_comb begin
        w_shift = {r_addr[2:0], 3'b000};
        case (r_size)
            2'b00:   w_mask_lo = 64'h0000_0000_0000_00FF;
            2'b01:   w_mask_lo = 64'h0000_0000_0000_FFFF;
            2'b10:   w_mask_lo = 64'h0000_0000_FFFF_FFFF;
            default: w_mask_lo = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_mask  = w_mask_lo << w_shift;
        w_merge = (mem_rdata & ~w_mask) | ((r_wdata & w_mask_lo) << w_shift);
        w_field = mem_rdata >> w_shift;
        case (r_size)
            2'b00:   w_ext = r_uns ? {56'h0, w_field[7:0]}  : {{56{w_field[7]}}, w_field[7:0]};
            2'b01:   w_ext = r_uns ? {48'h0, w_field[15:0]} : {{48{w_field[15]}}, w_field[15:0]};
            2'b10:   w_ext = r_uns ? {32'h0, w_field[31:0]} : {{32{w_field[31]}}, w_field[31:0]};
            default: w_ext = w_field;
        endcase
    end

    assign w_rd_last = (r_cnt == LAT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (w_misalign)                       w_next = RESP;
                    else if (req_we && req_size == 2'b11) w_next = WR;
                    else                                  w_next = RD;
`else
                    if (req_we && req_size == 2'b11) w_next = WR;
                    else                             w_next = RD;
`endif
                end
            end
            RD:      if (w_rd_last) w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 64'h0;
            r_wdata <= 64'h0;
            r_rdata <= 64'h0;
            r_cnt   <= 3'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_rdata <= 64'h0;
                r_cnt   <= 3'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                r_addr  <= req_addr;
                r_err   <= w_misalign;
`else
                r_addr  <= w_align_addr;
`endif
            end
            if (r_state == RD) begin
                r_cnt <= r_cnt + 3'd1;
                if (w_rd_last) begin
                    if (r_we) r_wdata <= w_merge;
                    else      r_rdata <= w_ext;
                end
            end
        end
    end

    // Outputs are gated by reset so a WR or RESP cycle coinciding with reset has no effect.
    assign req_ready  = (r_state == IDLE) && !reset;
    assign mem_read   = (r_state == RD) && !reset;
    assign mem_write  = (r_state == WR) && !reset;
    assign mem_addr   = (mem_read || mem_write) ? {r_addr[63:3], 3'b000} : 64'h0;
    assign mem_wdata  = mem_write ? r_wdata : 64'h0;
    assign resp_valid = (r_state == RESP) && !reset;
    assign resp_rdata = resp_valid ? r_rdata : 64'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err   = resp_valid && r_err;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two units (MEM_LAT 0 and 3), each with its own doubleword memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_v = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        sel = 1'b0;

    logic        rdy0, rv0, err0, mr0, mw0, rdy3, rv3, err3, mr3, mw3;
    logic [63:0] rd0, ma0, mwd0, mrd0, rd3, ma3, mwd3, mrd3;
    logic [63:0] mem0 [0:31];
    logic [63:0] mem3 [0:31];

    int ncmp = 0;
    int nfail = 0;
    int rd_c = 0, wr_c = 0, war_c = 0, both_c = 0, rv_c = 0;
    logic prev_rd = 1'b0;
    int last_war;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_v && !sel), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
        .resp_rdata(rd0), .resp_err(err0), .mem_read(mr0), .mem_write(mw0),
        .mem_addr(ma0), .mem_wdata(mwd0), .mem_rdata(mrd0));

    load_store_unit #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_v && sel), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
        .resp_rdata(rd3), .resp_err(err3), .mem_read(mr3), .mem_write(mw3),
        .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mrd3));

    assign mrd0 = mr0 ? mem0[ma0[7:3]] : 64'h0;
    assign mrd3 = mr3 ? mem3[ma3[7:3]] : 64'h0;
    always @(posedge clk) if (mw0) mem0[ma0[7:3]] <= mwd0;
    always @(posedge clk) if (mw3) mem3[ma3[7:3]] <= mwd3;

    logic        w_rdy, w_rv, w_err, w_rd, w_wr;
    logic [63:0] w_rdata;
    assign w_rdy   = sel ? rdy3 : rdy0;
    assign w_rv    = sel ? rv3  : rv0;
    assign w_err   = sel ? err3 : err0;
    assign w_rd    = sel ? mr3  : mr0;
    assign w_wr    = sel ? mw3  : mw0;
    assign w_rdata = sel ? rd3  : rd0;

    always @(negedge clk) begin
        if (w_rd) rd_c++;
        if (w_wr) begin
            wr_c++;
            if (prev_rd) war_c++;
        end
        if (w_rd && w_wr) both_c++;
        if (w_rv) rv_c++;
        prev_rd = w_rd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd, input int e_lat,
                       input int e_rd, input int e_wr, input logic [63:0] e_rdata, input logic e_err);
        int lat = 99, early = 0, rd0c, wr0c, war0, both0;
        logic [63:0] rdata = 64'hX;
        logic err = 1'bX;
        @(negedge clk);
        chk({tag, ".ready_in"}, 64'(w_rdy), 64'd1);
        req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd; req_v = 1'b1;
        @(posedge clk);
        #1;
        rd0c = rd_c; wr0c = wr_c; war0 = war_c; both0 = both_c;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (w_rv) begin
                lat = k; rdata = w_rdata; err = w_err;
                break;
            end
            if (w_rdy) early++;
        end
        req_v = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".rdata"}, rdata, e_rdata);
        chk({tag, ".err"}, 64'(err), 64'(e_err));
        chk({tag, ".rd_cycles"}, 64'(rd_c - rd0c), 64'(e_rd));
        chk({tag, ".wr_cycles"}, 64'(wr_c - wr0c), 64'(e_wr));
        chk({tag, ".ready_early"}, 64'(early), 64'd0);
        chk({tag, ".rd_wr_overlap"}, 64'(both_c - both0), 64'd0);
        chk({tag, ".ready_after"}, 64'(w_rdy), 64'd1);
        last_war = war_c - war0;
    endtask

    initial begin
        int wr_s, rv_s;
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.resp_valid", 64'(rv0), 64'd0);
        chk("rst.mem_read", 64'(mr0), 64'd0);
        chk("rst.mem_write", 64'(mw0), 64'd0);
        chk("rst.mem_addr", ma0, 64'h0);
        chk("rst.mem_wdata", mwd0, 64'h0);
        chk("rst.resp_rdata", rd0, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready0", 64'(rdy0), 64'd1);
        chk("rst.ready3", 64'(rdy3), 64'd1);

        // MEM_LAT = 0
        sel = 1'b0;
        txn("st_d08", 1, 2'b11, 0, 64'h08, 64'h1234_5678_ABCD_EF00, 2, 0, 1, 64'h0, 0);
        chk("st_d08.mem", mem0[1], 64'h1234_5678_ABCD_EF00);
        txn("ld_d08", 0, 2'b11, 0, 64'h08, 64'h0, 2, 1, 0, 64'h1234_5678_ABCD_EF00, 0);
        txn("st_d10", 1, 2'b11, 0, 64'h10, 64'hCAFE_BABE_DEAD_BEEF, 2, 0, 1, 64'h0, 0);
        txn("st_b13", 1, 2'b00, 0, 64'h13, 64'h55, 3, 1, 1, 64'h0, 0);
        chk("st_b13.mem", mem0[2], 64'hCAFE_BABE_55AD_BEEF);
        chk("st_b13.rd_before_wr", 64'(last_war), 64'd1);
        txn("st_d10b", 1, 2'b11, 0, 64'h10, 64'hCAFE_BABE_DEAD_BEEF, 2, 0, 1, 64'h0, 0);
        txn("ld_b17s", 0, 2'b00, 0, 64'h17, 64'h0, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FFCA, 0);
        txn("ld_b17u", 0, 2'b00, 1, 64'h17, 64'h0, 2, 1, 0, 64'h0000_0000_0000_00CA, 0);
        txn("ld_w14s", 0, 2'b10, 0, 64'h14, 64'h0, 2, 1, 0, 64'hFFFF_FFFF_CAFE_BABE, 0);
        txn("ld_h12u", 0, 2'b01, 1, 64'h12, 64'h0, 2, 1, 0, 64'h0000_0000_0000_DEAD, 0);
        txn("ld_h10s", 0, 2'b01, 0, 64'h10, 64'h0, 2, 1, 0, 64'hFFFF_FFFF_FFFF_BEEF, 0);
        txn("ld_d10", 0, 2'b11, 1, 64'h10, 64'h0, 2, 1, 0, 64'hCAFE_BABE_DEAD_BEEF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        txn("ld_w0A", 0, 2'b10, 1, 64'h0A, 64'h0, 1, 0, 0, 64'h0, 1);
        txn("st_h0D", 1, 2'b01, 0, 64'h0D, 64'h1234, 1, 0, 0, 64'h0, 1);
        chk("st_h0D.mem", mem0[1], 64'h1234_5678_ABCD_EF00);
`else
        txn("ld_w0A", 0, 2'b10, 1, 64'h0A, 64'h0, 2, 1, 0, 64'h0000_0000_ABCD_EF00, 0);
        txn("st_h0D", 1, 2'b01, 0, 64'h0D, 64'h1234, 3, 1, 1, 64'h0, 0);
        chk("st_h0D.mem", mem0[1], 64'h1234_1234_ABCD_EF00);
`endif
        txn("st_w08", 1, 2'b10, 0, 64'h08, 64'hFFFF_FFFF_0BAD_F00D, 3, 1, 1, 64'h0, 0);
        chk("st_w08.mem_lo", {32'h0, mem0[1][31:0]}, 64'h0000_0000_0BAD_F00D);

        // Reset during the RD cycle of a byte store.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0; req_addr = 64'h11; req_wdata = 64'h77; req_v = 1'b1;
        @(posedge clk);
        #1;
        req_v = 1'b0;
        wr_s = wr_c; rv_s = rv_c;
        @(negedge clk);
        chk("abort.in_rd", 64'(mr0), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort.ready", 64'(rdy0), 64'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("abort.no_write", 64'(wr_c - wr_s), 64'd0);
        chk("abort.no_resp", 64'(rv_c - rv_s), 64'd0);
        chk("abort.mem", mem0[2], 64'hCAFE_BABE_DEAD_BEEF);

        // MEM_LAT = 3
        sel = 1'b1;
        @(posedge clk);
        #1;
        txn("l3_st_d00", 1, 2'b11, 0, 64'h00, 64'hA5A5_0000_1111_5A5A, 2, 0, 1, 64'h0, 0);
        txn("l3_ld_d00", 0, 2'b11, 0, 64'h00, 64'h0, 5, 4, 0, 64'hA5A5_0000_1111_5A5A, 0);
        txn("l3_ld_b06", 0, 2'b00, 0, 64'h06, 64'h0, 5, 4, 0, 64'hFFFF_FFFF_FFFF_FFA5, 0);
        txn("l3_st_b01", 1, 2'b00, 0, 64'h01, 64'hC3, 6, 4, 1, 64'h0, 0);
        chk("l3_st_b01.mem", mem3[0], 64'hA5A5_0000_1111_C35A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
